// File: rtl/floo_wormhole_rr_arbiter.sv
// rtl/floo_wormhole_rr_arbiter.sv - packet-granular round-robin wormhole arbiter onto one NoC link
// Optional output register stage: PICOBELLO_ARB_OUT_REG_EN.
module floo_wormhole_rr_arbiter #(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned IdxW     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumInp-1:0]                valid_i,
    output logic [NumInp-1:0]                ready_o,
    input  logic [NumInp-1:0][DataWidth-1:0] data_i,
    input  logic [NumInp-1:0]                last_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DataWidth-1:0]             data_o,
    output logic                             last_o,
    output logic [IdxW-1:0]                  grant_idx_o,
    output logic                             locked_o
);

    typedef enum logic {IDLE, LOCKED} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [IdxW-1:0]      rr_q, rr_d, lock_q, lock_d;
    logic [IdxW-1:0]      sel, cur_idx;
    logic [IdxW:0]        cand;
    logic                 any_valid, sel_valid, sel_last, fwd_ready, handshake;
    logic [DataWidth-1:0] sel_data;

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
        if ({1'b0, idx} + 1'b1 >= (IdxW+1)'(NumInp)) return '0;
        return idx + 1'b1;
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        sel  = rr_q;
        cand = '0;
        for (int k = NumInp - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NumInp)) cand = cand - (IdxW+1)'(NumInp);
            if (valid_i[cand[IdxW-1:0]]) sel = cand[IdxW-1:0];
        end
    end

    always_comb begin
        any_valid = |valid_i;
        cur_idx   = (fsm_q == LOCKED) ? lock_q : sel;
        sel_valid = (fsm_q == LOCKED) ? valid_i[lock_q] : any_valid;
        sel_data  = sel_valid ? data_i[cur_idx] : '0;
        sel_last  = sel_valid & last_i[cur_idx];
        handshake = sel_valid & fwd_ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q  <= IDLE;
            rr_q   <= '0;
            lock_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            rr_q   <= rr_d;
            lock_q <= lock_d;
        end
    end

    // A stalled head also locks, so a later higher-priority request cannot steal the grant.
    always_comb begin
        fsm_d  = fsm_q;
        rr_d   = rr_q;
        lock_d = lock_q;
        case (fsm_q)
            IDLE: begin
                if (sel_valid) begin
                    if (handshake && sel_last) begin
                        rr_d = wrap_inc(sel);
                    end else begin
                        lock_d = sel;
                        fsm_d  = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (handshake && sel_last) begin
                    rr_d  = wrap_inc(lock_q);
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = '0;
        if (fsm_q == LOCKED || any_valid) ready_o[cur_idx] = fwd_ready;
        grant_idx_o = cur_idx;
        locked_o    = (fsm_q == LOCKED);
    end

`ifdef PICOBELLO_ARB_OUT_REG_EN
    logic                 full_q, full_d, out_last_q, out_last_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;

    // The register accepts a new flit in the same cycle it drains.
    assign fwd_ready = !full_q | ready_i;

    always_comb begin
        full_d     = full_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (fwd_ready) begin
            full_d = sel_valid;
            if (sel_valid) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q     <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = full_q ? out_data_q : '0;
    assign last_o  = full_q & out_last_q;
`else
    assign fwd_ready = ready_i;
    assign valid_o   = sel_valid;
    assign data_o    = sel_data;
    assign last_o    = sel_last;
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_o));

    for (genvar g = 0; g < NumInp; g++) begin : g_hold
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_i[g] && !ready_o[g]) |=> (valid_i[g] && $stable(data_i[g])));
    end
`endif

endmodule

// File: tb/tb_floo_wormhole_rr_arbiter.sv
// tb/tb_floo_wormhole_rr_arbiter.sv - directed self-checking bench for floo_wormhole_rr_arbiter
module tb_floo_wormhole_rr_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N-1:0]        valid_i, ready_o, last_i;
    logic [N-1:0][W-1:0] data_i;
    logic                valid_o, ready_i, last_o, locked_o;
    logic [W-1:0]        data_o;
    logic [1:0]          grant_idx_o;

    int checks = 0;
    int errors = 0;

    floo_wormhole_rr_arbiter #(.NumInp(N), .DataWidth(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .last_i(last_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
        .grant_idx_o(grant_idx_o), .locked_o(locked_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
        #12;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_o: got %0h expected 0", valid_o); end
        checks++; if (ready_o !== 4'h0) begin errors++; $display("FAIL rst_ready_o: got %0h expected 0", ready_o); end
        checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL rst_data_o: got %0h expected 0", data_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL rst_last_o: got %0h expected 0", last_o); end
        checks++; if (grant_idx_o !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_idx_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0h expected 0", locked_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++; if ({valid_o, ready_o, locked_o, grant_idx_o} !== 8'h0) begin
            errors++; $display("FAIL post_rst_outputs: got %0h expected 0", {valid_o, ready_o, locked_o, grant_idx_o});
        end
    endtask

`ifndef PICOBELLO_ARB_OUT_REG_EN
    task automatic test_round_robin;
        valid_i = 4'hF; last_i = 4'hF; ready_i = 1'b1;
        for (int i = 0; i < N; i++) data_i[i] = 64'hA0 + 64'(i);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (grant_idx_o !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, grant_idx_o, k % 4); end
            checks++; if (data_o !== 64'hA0 + 64'(k % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %0h expected %0h", k, data_o, 64'hA0 + 64'(k % 4)); end
            checks++; if (ready_o !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %0h expected %0h", k, ready_o, 4'(1 << (k % 4))); end
            checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL rr_locked[%0d]: got %0h expected 0", k, locked_o); end
            tick();
            if (k >= 4) valid_i[k % 4] = 1'b0;
        end
        #1;
        checks++; if (valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
            errors++; $display("FAIL rr_idle: got valid %0h grant %0d expected valid 0 grant 0", valid_o, grant_idx_o);
        end
    endtask

    task automatic test_wormhole_lock;
        tick();
        valid_i = 4'b0001; last_i = 4'b0001; data_i[0] = 64'hA0; ready_i = 1'b1;
        #1;
        checks++; if (grant_idx_o !== 2'd0) begin errors++; $display("FAIL wh_pre_grant: got %0d expected 0", grant_idx_o); end
        tick();
        valid_i = 4'b0011; data_i[1] = 64'h1A;
        #1;
        checks++; if (grant_idx_o !== 2'd1 || data_o !== 64'h1A || last_o !== 1'b0) begin
            errors++; $display("FAIL wh_head: got grant %0d data %0h last %0h expected grant 1 data 1a last 0", grant_idx_o, data_o, last_o);
        end
        checks++; if (ready_o !== 4'b0010 || locked_o !== 1'b0) begin
            errors++; $display("FAIL wh_head_ctl: got ready %0h locked %0h expected ready 2 locked 0", ready_o, locked_o);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            data_i[1] = 64'h1B; ready_i = 1'b0;
            #1;
            checks++; if (locked_o !== 1'b1 || grant_idx_o !== 2'd1 || valid_o !== 1'b1) begin
                errors++; $display("FAIL wh_stall[%0d]: got locked %0h grant %0d valid %0h expected 1 1 1", c, locked_o, grant_idx_o, valid_o);
            end
            checks++; if (ready_o !== 4'b0000 || data_o !== 64'h1B) begin
                errors++; $display("FAIL wh_stall_data[%0d]: got ready %0h data %0h expected ready 0 data 1b", c, ready_o, data_o);
            end
        end
        tick();
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 4'b0010 || data_o !== 64'h1B) begin
            errors++; $display("FAIL wh_body: got ready %0h data %0h expected ready 2 data 1b", ready_o, data_o);
        end
        data_i[2] = 64'hC2;
        for (int c = 0; c < 2; c++) begin
            tick();
            valid_i = 4'b0101;
            #1;
            checks++; if (valid_o !== 1'b0 || data_o !== 64'h0) begin
                errors++; $display("FAIL wh_bubble[%0d]: got valid %0h data %0h expected 0 0", c, valid_o, data_o);
            end
            checks++; if ((ready_o & 4'b1101) !== 4'b0000 || grant_idx_o !== 2'd1 || locked_o !== 1'b1) begin
                errors++; $display("FAIL wh_bubble_ctl[%0d]: got ready %0h grant %0d locked %0h expected other-ready 0 grant 1 locked 1", c, ready_o, grant_idx_o, locked_o);
            end
        end
        tick();
        valid_i = 4'b0111; last_i = 4'b1111; data_i[1] = 64'h1C;
        #1;
        checks++; if (data_o !== 64'h1C || last_o !== 1'b1 || ready_o !== 4'b0010 || locked_o !== 1'b1) begin
            errors++; $display("FAIL wh_tail: got data %0h last %0h ready %0h locked %0h expected 1c 1 2 1", data_o, last_o, ready_o, locked_o);
        end
        tick();
        valid_i = 4'b0101;
        #1;
        checks++; if (grant_idx_o !== 2'd2 || data_o !== 64'hC2 || locked_o !== 1'b0 || ready_o !== 4'b0100) begin
            errors++; $display("FAIL wh_next: got grant %0d data %0h locked %0h ready %0h expected 2 c2 0 4", grant_idx_o, data_o, locked_o, ready_o);
        end
    endtask

    task automatic test_wrap;
        tick();
        valid_i = 4'b1001; data_i[3] = 64'hD3;
        #1;
        checks++; if (grant_idx_o !== 2'd3 || data_o !== 64'hD3 || ready_o !== 4'b1000) begin
            errors++; $display("FAIL wrap_first: got grant %0d data %0h ready %0h expected 3 d3 8", grant_idx_o, data_o, ready_o);
        end
        tick();
        #1;
        checks++; if (grant_idx_o !== 2'd0 || data_o !== 64'hA0) begin
            errors++; $display("FAIL wrap_second: got grant %0d data %0h expected 0 a0", grant_idx_o, data_o);
        end
        tick();
        valid_i = 4'b1000;
        #1;
        checks++; if (grant_idx_o !== 2'd3) begin errors++; $display("FAIL wrap_third: got grant %0d expected 3", grant_idx_o); end
        tick();
        valid_i = 4'b0000;
        #1;
        checks++; if (grant_idx_o !== 2'd0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL wrap_idle: got grant %0d valid %0h expected 0 0", grant_idx_o, valid_o);
        end
    endtask

    task automatic test_stall_lock;
        tick();
        valid_i = 4'b0100; last_i = 4'b0110; data_i[2] = 64'hE2; data_i[1] = 64'hE1; ready_i = 1'b0;
        #1;
        checks++; if (grant_idx_o !== 2'd2 || locked_o !== 1'b0 || ready_o !== 4'b0000) begin
            errors++; $display("FAIL stall_head: got grant %0d locked %0h ready %0h expected 2 0 0", grant_idx_o, locked_o, ready_o);
        end
        tick();
        valid_i = 4'b0110;
        #1;
        checks++; if (grant_idx_o !== 2'd2 || locked_o !== 1'b1 || data_o !== 64'hE2) begin
            errors++; $display("FAIL stall_hold: got grant %0d locked %0h data %0h expected 2 1 e2", grant_idx_o, locked_o, data_o);
        end
        tick();
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 4'b0100 || last_o !== 1'b1) begin
            errors++; $display("FAIL stall_release: got ready %0h last %0h expected 4 1", ready_o, last_o);
        end
        tick();
        valid_i = 4'b0010;
        #1;
        checks++; if (grant_idx_o !== 2'd1 || locked_o !== 1'b0 || data_o !== 64'hE1) begin
            errors++; $display("FAIL stall_next: got grant %0d locked %0h data %0h expected 1 0 e1", grant_idx_o, locked_o, data_o);
        end
        tick();
        valid_i = 4'b0000;
        #1;
        checks++; if (grant_idx_o !== 2'd2) begin errors++; $display("FAIL stall_rr: got grant %0d expected 2", grant_idx_o); end
    endtask

    task automatic test_reset_mid_packet;
        tick();
        valid_i = 4'b0001; last_i = 4'b0000; data_i[0] = 64'hF0; ready_i = 1'b1;
        #1;
        checks++; if (grant_idx_o !== 2'd0) begin errors++; $display("FAIL mid_head: got grant %0d expected 0", grant_idx_o); end
        tick();
        valid_i = 4'b0000;
        #1;
        checks++; if (locked_o !== 1'b1 || grant_idx_o !== 2'd0) begin
            errors++; $display("FAIL mid_locked: got locked %0h grant %0d expected 1 0", locked_o, grant_idx_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (locked_o !== 1'b0 || grant_idx_o !== 2'd0) begin
            errors++; $display("FAIL mid_async_rst: got locked %0h grant %0d expected 0 0", locked_o, grant_idx_o);
        end
        #1;
        rst_ni = 1'b1;
        tick();
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got locked %0h expected 0", locked_o); end
    endtask
`else
    task automatic test_out_reg;
        valid_i = 4'hF; last_i = 4'hF; ready_i = 1'b1;
        for (int i = 0; i < N; i++) data_i[i] = 64'hA0 + 64'(i);
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 4'b0001) begin
            errors++; $display("FAIL reg_first: got valid %0h ready %0h expected 0 1", valid_o, ready_o);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (valid_o !== 1'b1 || data_o !== 64'hA0 + 64'(k - 1) || grant_idx_o !== 2'(k % 4)) begin
                errors++; $display("FAIL reg_stream[%0d]: got valid %0h data %0h grant %0d expected 1 %0h %0d", k, valid_o, data_o, grant_idx_o, 64'hA0 + 64'(k - 1), k % 4);
            end
        end
        tick();
        ready_i = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== 64'hA0 || ready_o !== 4'b0000) begin
                errors++; $display("FAIL reg_hold[%0d]: got valid %0h data %0h ready %0h expected 1 a0 0", c, valid_o, data_o, ready_o);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef PICOBELLO_ARB_OUT_REG_EN
        test_round_robin();
        test_wormhole_lock();
        test_wrap();
        test_stall_lock();
        test_reset_mid_packet();
`else
        test_out_reg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
